// File: rtl/seq_mult_responder_if.sv
// seq_mult_responder_if
//   Operand/product handshake bundle for the sequential multiplier.
//   Parameter WIDTH : operand width; the product P is 2*WIDTH bits.
//   Signals:
//     in_valid  : master -> slave, operand pair present on A/B
//     in_ready  : slave  -> master, responder can accept an operand pair
//     A, B      : master -> slave, unsigned multiplicand / multiplier
//     out_valid : slave  -> master, P holds a finished product
//     out_ready : master -> slave, consumer accepts P
//     P         : slave  -> master, unsigned product
//   Modports: master (operand source / product sink), slave (responder).
interface seq_mult_responder_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] P;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, P
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, P
  );
endinterface

// File: rtl/seq_mult_responder.sv
// seq_mult_responder
//   Shift-add unsigned multiplier, one multiplier bit per clock. Accepts an
//   operand pair on the input handshake, iterates in CALC, then presents the
//   product until the consumer takes it.
//   Parameters:
//     WIDTH : operand width (2..32), product is 2*WIDTH bits
//     CNT_W : width of the saturating delivered-product counter
//   Ports:
//     clk      : system clock, rising edge
//     rst_n    : asynchronous active-low reset
//     bus      : seq_mult_responder_if slave modport (in_valid/in_ready/A/B,
//                out_valid/out_ready/P)
//     busy     : high while in CALC or DONE
//     op_count : products delivered since reset, saturating at all-ones
//   Build option:
//     SEQ_MULT_EARLY_TERM_EN : when defined, CALC also ends as soon as the
//                              remaining multiplier bits are all zero.
//
//   state  | meaning
//   -------+-----------------------------------------------------
//   IDLE   | in_ready high, waiting for an operand pair
//   CALC   | one multiplier bit consumed per clock
//   DONE   | out_valid high, P held until out_ready
module seq_mult_responder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_mult_responder_if.slave bus,
  output logic                busy,
  output logic [CNT_W-1:0]    op_count
);

  localparam int PW = 2 * WIDTH;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  logic [1:0]       state;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_next;
  logic [PW-1:0]    p_q;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] mplier_next;
  logic [BW-1:0]    bitcnt;
  logic             out_valid_q;
  logic             calc_last;

  // acc cannot overflow: the full product of two WIDTH-bit values fits in PW.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end
  end

  assign mplier_next = mplier >> 1;

`ifdef SEQ_MULT_EARLY_TERM_EN
  // Once the shifted multiplier is empty, further iterations add nothing.
  assign calc_last = (bitcnt == LAST_BIT) || (mplier_next == '0);
`else
  assign calc_last = (bitcnt == LAST_BIT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      mcand       <= '0;
      acc         <= '0;
      mplier      <= '0;
      bitcnt      <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      op_count    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            mcand  <= {{WIDTH{1'b0}}, bus.A};
            mplier <= bus.B;
            acc    <= '0;
            bitcnt <= '0;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier_next;
          bitcnt <= bitcnt + BW'(1);
          if (calc_last) begin
            p_q         <= acc_next;
            out_valid_q <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (op_count != '1) begin
              op_count <= op_count + CNT_W'(1);
            end
            state <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.P         = p_q;
  assign busy          = (state == S_CALC) || (state == S_DONE);

endmodule

// File: tb/tb_seq_mult_responder.sv
module tb_seq_mult_responder;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int checks;
  int failures;
  int exp_count;

  seq_mult_responder_if #(.WIDTH(WIDTH)) bus ();

  seq_mult_responder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: product is plain arithmetic, latency is WIDTH or,
  // with early termination, the position of B's top set bit (minimum 1).
  function automatic logic [2*WIDTH-1:0] ref_prod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (2*WIDTH)'(a) * (2*WIDTH)'(b);
  endfunction

  function automatic int ref_lat(input logic [WIDTH-1:0] b);
    int l;
`ifdef SEQ_MULT_EARLY_TERM_EN
    l = 1;
    for (int i = 0; i < WIDTH; i++) if (b[i]) l = i + 1;
`else
    l = WIDTH;
`endif
    return l;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.A = '0;
    bus.B = '0;
    exp_count = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n;
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A = WIDTH'($urandom);
    bus.B = WIDTH'($urandom);
  endtask

  task automatic wait_done(output int lat, output bit timeout, output bit ready_ok);
    lat = 0;
    timeout = 1'b0;
    ready_ok = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.out_valid) break;
      if (bus.in_ready || !busy) ready_ok = 1'b0;
      if (lat > 64) begin
        timeout = 1'b1;
        break;
      end
    end
  endtask

  task automatic accept();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.P !== '0) begin failures++; $display("FAIL reset_P got=%0d exp=0", bus.P); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (op_count !== '0) begin failures++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
  endtask

  task automatic test_single();
    int lat; bit to; bit rok;
    start_op(8'd1, 8'd1);
    wait_done(lat, to, rok);
    checks++; if (to) begin failures++; $display("FAIL single_timeout got=timeout exp=out_valid"); end
    checks++; if (bus.P !== ref_prod(8'd1, 8'd1)) begin failures++; $display("FAIL single_P got=%0d exp=%0d", bus.P, ref_prod(8'd1, 8'd1)); end
    checks++; if (lat !== ref_lat(8'd1)) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", lat, ref_lat(8'd1)); end
    accept();
    exp_count++;
    checks++; if (op_count !== CNT_W'(exp_count)) begin failures++; $display("FAIL single_op_count got=%0d exp=%0d", op_count, exp_count); end
  endtask

  task automatic test_sequence();
    logic [WIDTH-1:0] av [4] = '{8'd1, 8'd2, 8'd3, 8'd3};
    logic [WIDTH-1:0] bv [4] = '{8'd2, 8'd3, 8'd3, 8'd2};
    int lat; bit to; bit rok;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      start_op(av[i], bv[i]);
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL seq_ready_after_capture idx=%0d got=%b exp=0", i, bus.in_ready); end
      wait_done(lat, to, rok);
      checks++; if (bus.P !== ref_prod(av[i], bv[i]) || to) begin failures++; $display("FAIL seq_P idx=%0d got=%0d exp=%0d", i, bus.P, ref_prod(av[i], bv[i])); end
      checks++; if (!rok || bus.in_ready !== 1'b0) begin failures++; $display("FAIL seq_in_ready_low idx=%0d got=%b exp=0", i, bus.in_ready); end
      accept();
      exp_count++;
      checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL seq_after_handshake idx=%0d in_ready=%b out_valid=%b exp=1/0", i, bus.in_ready, bus.out_valid); end
    end
    checks++; if (op_count !== 16'd4) begin failures++; $display("FAIL seq_op_count got=%0d exp=4", op_count); end
  endtask

  task automatic test_edges();
    logic [WIDTH-1:0] av [3] = '{8'd255, 8'd0, 8'd200};
    logic [WIDTH-1:0] bv [3] = '{8'd255, 8'd200, 8'd0};
    int lat; bit to; bit rok;
    for (int i = 0; i < 3; i++) begin
      start_op(av[i], bv[i]);
      wait_done(lat, to, rok);
      checks++; if (bus.P !== ref_prod(av[i], bv[i]) || to) begin failures++; $display("FAIL edge_P idx=%0d got=%0d exp=%0d", i, bus.P, ref_prod(av[i], bv[i])); end
      checks++; if (lat !== ref_lat(bv[i])) begin failures++; $display("FAIL edge_latency idx=%0d got=%0d exp=%0d", i, lat, ref_lat(bv[i])); end
      accept();
      exp_count++;
    end
    checks++; if (op_count !== CNT_W'(exp_count)) begin failures++; $display("FAIL edge_op_count got=%0d exp=%0d", op_count, exp_count); end
  endtask

  task automatic test_backpressure();
    int lat; bit to; bit rok;
    start_op(8'd3, 8'd2);
    wait_done(lat, to, rok);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.in_valid = c[0];
      bus.A = WIDTH'($urandom);
      bus.B = WIDTH'($urandom);
      checks++; if (bus.P !== 16'd6 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold cyc=%0d P=%0d out_valid=%b in_ready=%b exp=6/1/0", c, bus.P, bus.out_valid, bus.in_ready); end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (op_count !== CNT_W'(exp_count)) begin failures++; $display("FAIL bp_count_before got=%0d exp=%0d", op_count, exp_count); end
    accept();
    exp_count++;
    checks++; if (bus.out_valid !== 1'b0 || op_count !== CNT_W'(exp_count)) begin failures++; $display("FAIL bp_consume out_valid=%b op_count=%0d exp=0/%0d", bus.out_valid, op_count, exp_count); end
    @(negedge clk);
    checks++; if (bus.P !== 16'd6) begin failures++; $display("FAIL bp_P_retained got=%0d exp=6", bus.P); end
  endtask

  task automatic test_reset_mid();
    int lat; bit to; bit rok;
    start_op(8'd7, 8'd9);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_count = 0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.P !== '0 || bus.in_ready !== 1'b1 || op_count !== '0 || busy !== 1'b0) begin failures++; $display("FAIL midreset_state out_valid=%b P=%0d in_ready=%b op_count=%0d busy=%b exp=0/0/1/0/0", bus.out_valid, bus.P, bus.in_ready, op_count, busy); end
    @(negedge clk);
    rst_n = 1'b1;
    start_op(8'd2, 8'd2);
    wait_done(lat, to, rok);
    checks++; if (bus.P !== 16'd4 || to) begin failures++; $display("FAIL midreset_next_P got=%0d exp=4", bus.P); end
    accept();
    exp_count++;
    checks++; if (op_count !== CNT_W'(exp_count)) begin failures++; $display("FAIL midreset_op_count got=%0d exp=%0d", op_count, exp_count); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b;
    int lat; bit to; bit rok; int stall;
    for (int i = 0; i < 25; i++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      if (i % 5 == 0) b = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
      start_op(a, b);
      wait_done(lat, to, rok);
      checks++; if (bus.P !== ref_prod(a, b) || to) begin failures++; $display("FAIL rand_P a=%0d b=%0d got=%0d exp=%0d", a, b, bus.P, ref_prod(a, b)); end
      checks++; if (lat !== ref_lat(b) || !rok) begin failures++; $display("FAIL rand_latency b=%0d got=%0d exp=%0d ready_low=%b", b, lat, ref_lat(b), rok); end
      stall = $urandom_range(0, 3);
      repeat (stall) @(negedge clk);
      checks++; if (bus.P !== ref_prod(a, b) || bus.out_valid !== 1'b1) begin failures++; $display("FAIL rand_stall_hold got=%0d/%b exp=%0d/1", bus.P, bus.out_valid, ref_prod(a, b)); end
      accept();
      exp_count++;
    end
    checks++; if (op_count !== CNT_W'(exp_count)) begin failures++; $display("FAIL rand_op_count got=%0d exp=%0d", op_count, exp_count); end
  endtask

`ifdef SEQ_MULT_EARLY_TERM_EN
  task automatic test_early_term();
    logic [WIDTH-1:0] av [3] = '{8'd9, 8'd5, 8'd1};
    logic [WIDTH-1:0] bv [3] = '{8'd0, 8'd2, 8'd128};
    int el [3] = '{1, 2, 8};
    int lat; bit to; bit rok;
    for (int i = 0; i < 3; i++) begin
      start_op(av[i], bv[i]);
      wait_done(lat, to, rok);
      checks++; if (lat !== el[i] || to) begin failures++; $display("FAIL early_latency idx=%0d got=%0d exp=%0d", i, lat, el[i]); end
      checks++; if (bus.P !== ref_prod(av[i], bv[i])) begin failures++; $display("FAIL early_P idx=%0d got=%0d exp=%0d", i, bus.P, ref_prod(av[i], bv[i])); end
      accept();
      exp_count++;
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    exp_count = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.A = '0;
    bus.B = '0;
    test_reset();
    test_single();
    test_sequence();
    test_edges();
    test_backpressure();
    test_reset_mid();
`ifdef SEQ_MULT_EARLY_TERM_EN
    test_early_term();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
